// File: rtl/seg_link_pkg.sv
// Shared definitions for the serial 7-segment link: frame geometry, segment
// codes, slot tag layout and the receive FSM encoding.
package seg_link_pkg;

    localparam int NUM_DIGITS = 6;
    localparam int NUM_SEGS   = 7;
    localparam int PAT_W      = NUM_DIGITS * NUM_SEGS;
    localparam int BCD_W      = 4 * NUM_DIGITS;

    localparam logic [6:0] CODE_0 = 7'h3F;
    localparam logic [6:0] CODE_1 = 7'h06;
    localparam logic [6:0] CODE_2 = 7'h5B;
    localparam logic [6:0] CODE_3 = 7'h4F;
    localparam logic [6:0] CODE_4 = 7'h66;
    localparam logic [6:0] CODE_5 = 7'h6D;
    localparam logic [6:0] CODE_6 = 7'h7D;
    localparam logic [6:0] CODE_7 = 7'h07;
    localparam logic [6:0] CODE_8 = 7'h7F;
    localparam logic [6:0] CODE_9 = 7'h67;
    localparam logic [6:0] CODE_BLANK = 7'h00;

    localparam logic [3:0] BLANK_CODE   = 4'hA;
    localparam logic [3:0] INVALID_CODE = 4'hF;

    typedef enum logic {
        ST_HUNT,
        ST_ASSEMBLE
    } rx_state_e;

    typedef struct packed {
        logic [2:0] disp;
        logic [2:0] seg;
    } slot_tag_t;

    typedef struct packed {
        logic      ampm;
        logic      pol;
        slot_tag_t tag;
        logic      ser;
    } link_sample_t;

    localparam slot_tag_t FIRST_TAG = slot_tag_t'(6'h00);
    localparam slot_tag_t LAST_TAG  = slot_tag_t'({3'd5, 3'd6});
    localparam slot_tag_t IDLE_TAG  = slot_tag_t'(6'h3F);

    function automatic slot_tag_t next_tag(input slot_tag_t t);
        slot_tag_t n;
        n = t;
        if (t.seg == 3'(NUM_SEGS - 1)) begin
            n.seg  = 3'd0;
            n.disp = t.disp + 3'd1;
        end else begin
            n.seg = t.seg + 3'd1;
        end
        return n;
    endfunction

    function automatic logic [5:0] bit_index(input slot_tag_t t);
        return 6'(t.disp) * 6'd7 + 6'(t.seg);
    endfunction

endpackage

// File: rtl/seg7_to_bcd.sv
// Maps one active-high 7-segment pattern back to its digit value; blank
// patterns give BLANK_CODE and anything unrecognised gives INVALID_CODE.
module seg7_to_bcd
    import seg_link_pkg::*;
(
    input  logic [6:0] pattern_i,
    output logic [3:0] bcd_o
);

    always_comb begin
        bcd_o = INVALID_CODE;
        case (pattern_i)
            CODE_0:     bcd_o = 4'd0;
            CODE_1:     bcd_o = 4'd1;
            CODE_2:     bcd_o = 4'd2;
            CODE_3:     bcd_o = 4'd3;
            CODE_4:     bcd_o = 4'd4;
            CODE_5:     bcd_o = 4'd5;
            CODE_6:     bcd_o = 4'd6;
            CODE_7:     bcd_o = 4'd7;
            CODE_8:     bcd_o = 4'd8;
            CODE_9:     bcd_o = 4'd9;
            CODE_BLANK: bcd_o = BLANK_CODE;
            default:    bcd_o = INVALID_CODE;
        endcase
    end

endmodule

// File: rtl/seg_frame_rx.sv
// Receiver for the serial 7-segment link: synchronizes the link lines, samples
// each settled slot, reassembles 6-digit frames and publishes them atomically.
module seg_frame_rx
    import seg_link_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int SETTLE      = 4,
    parameter int TIMEOUT     = 20000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ser_seg_i,
    input  logic [2:0]       seg_sel_i,
    input  logic [2:0]       disp_sel_i,
    input  logic             ampm_in_i,
    input  logic             pol_low_i,
    output logic [PAT_W-1:0] seg_pat_o,
    output logic [BCD_W-1:0] digit_bcd_o,
    output logic             ampm_out_o,
    output logic             frame_valid_o,
    output logic             sync_err_o,
    output logic             link_lost_o
);

    localparam int SETTLE_W = $clog2(SETTLE + 1);
    localparam int IDLE_W   = $clog2(TIMEOUT + 1);
    localparam link_sample_t SYNC_RESET = '{ampm: 1'b0, pol: 1'b0, tag: IDLE_TAG, ser: 1'b0};

    link_sample_t          sync_q [SYNC_STAGES];
    link_sample_t          link_raw;
    link_sample_t          link_s;
    slot_tag_t             track_q, track_d;
    slot_tag_t             last_tag_q, last_tag_d;
    logic [SETTLE_W-1:0]   settle_q, settle_d;
    logic [IDLE_W-1:0]     idle_q, idle_d;
    logic                  link_lost_q, link_lost_d;
    rx_state_e             state_q, state_d;
    slot_tag_t             expect_q, expect_d;
    logic [PAT_W-1:0]      work_q, work_d;
    logic [PAT_W-1:0]      seg_pat_q;
    logic                  ampm_q, frame_valid_q, sync_err_q;
    logic                  sample_event, sample_bit, timeout_hit, commit, bad_slot;

    assign link_raw = {ampm_in_i, pol_low_i, disp_sel_i, seg_sel_i, ser_seg_i};
    assign link_s   = sync_q[SYNC_STAGES-1];

    // Tag lines reset to the idle tag so leaving reset never looks like a slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SYNC_RESET;
        end else begin
            sync_q[0] <= link_raw;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    // track_q follows the synced tag; a slot is sampled once it has held for
    // SETTLE cycles and still differs from the last sampled tag.
    always_comb begin
        track_d      = track_q;
        settle_d     = settle_q;
        last_tag_d   = last_tag_q;
        sample_event = 1'b0;
        if (link_s.tag != track_q) begin
            track_d  = link_s.tag;
            settle_d = SETTLE_W'(1);
        end else if (track_q != last_tag_q) begin
            if (settle_q >= SETTLE_W'(SETTLE - 1)) begin
                sample_event = 1'b1;
                last_tag_d   = track_q;
                settle_d     = '0;
            end else begin
                settle_d = settle_q + 1'b1;
            end
        end
    end

    assign sample_bit  = link_s.ser ^ link_s.pol;
    assign timeout_hit = !sample_event && (idle_q == IDLE_W'(TIMEOUT - 1));

    always_comb begin
        idle_d      = sample_event ? '0 :
                      (idle_q == IDLE_W'(TIMEOUT)) ? idle_q : idle_q + 1'b1;
        link_lost_d = sample_event ? 1'b0 : (timeout_hit ? 1'b1 : link_lost_q);
    end

    always_comb begin
        state_d  = state_q;
        expect_d = expect_q;
        work_d   = work_q;
        commit   = 1'b0;
        bad_slot = 1'b0;
        if (sample_event) begin
            case (state_q)
                ST_HUNT: begin
                    if (track_q == FIRST_TAG) begin
                        work_d    = '0;
                        work_d[0] = sample_bit;
                        expect_d  = next_tag(FIRST_TAG);
                        state_d   = ST_ASSEMBLE;
                    end
                end
                ST_ASSEMBLE: begin
                    if (track_q == expect_q) begin
                        work_d[bit_index(track_q)] = sample_bit;
                        if (track_q == LAST_TAG) begin
                            commit  = 1'b1;
                            state_d = ST_HUNT;
                        end else begin
                            expect_d = next_tag(expect_q);
                        end
                    end else begin
                        // A slot at (0,0) is a legitimate frame start, so resync on it.
                        bad_slot = 1'b1;
                        work_d   = '0;
                        if (track_q == FIRST_TAG) begin
                            work_d[0] = sample_bit;
                            expect_d  = next_tag(FIRST_TAG);
                        end else begin
                            state_d = ST_HUNT;
                        end
                    end
                end
                default: state_d = ST_HUNT;
            endcase
        end else if (timeout_hit) begin
            state_d = ST_HUNT;
            work_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            track_q     <= IDLE_TAG;
            last_tag_q  <= IDLE_TAG;
            settle_q    <= '0;
            idle_q      <= '0;
            link_lost_q <= 1'b0;
            state_q     <= ST_HUNT;
            expect_q    <= FIRST_TAG;
            work_q      <= '0;
        end else begin
            track_q     <= track_d;
            last_tag_q  <= last_tag_d;
            settle_q    <= settle_d;
            idle_q      <= idle_d;
            link_lost_q <= link_lost_d;
            state_q     <= state_d;
            expect_q    <= expect_d;
            work_q      <= work_d;
        end
    end

    // Committed view only changes on a complete frame, all fields together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_pat_q     <= '0;
            ampm_q        <= 1'b0;
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            frame_valid_q <= commit;
            sync_err_q    <= bad_slot;
            if (commit) begin
                seg_pat_q <= work_d;
                ampm_q    <= link_s.ampm;
            end
        end
    end

    for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_decode
        seg7_to_bcd u_decode (
            .pattern_i(seg_pat_q[NUM_SEGS*d +: NUM_SEGS]),
            .bcd_o    (digit_bcd_o[4*d +: 4])
        );
    end

    assign seg_pat_o     = seg_pat_q;
    assign ampm_out_o    = ampm_q;
    assign frame_valid_o = frame_valid_q;
    assign sync_err_o    = sync_err_q;
    assign link_lost_o   = link_lost_q;

endmodule
